// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged system reset release with done handshakes, timeout/retry and heartbeat
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 2,
  parameter int HB_BIT         = 27
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic                          ext_rst_n_i,
  input  logic [NUM_STAGES-1:0]         stage_done_i,
  output logic [NUM_STAGES-1:0]         stage_rst_o,
  output logic                          all_done_o,
  output logic                          timeout_o,
  output logic [$clog2(NUM_STAGES):0]   fail_stage_o,
  output logic [3:0]                    retry_cnt_o,
  output logic                          fault_o,
  output logic                          heartbeat_o
);

  localparam int SW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int FW   = $clog2(NUM_STAGES) + 1;
  localparam int CMAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_WAIT,
    ST_RUN,
    ST_FAULT
  } state_e;

  logic                  ext_meta_q, ext_sync_q;
  state_e                state_q, state_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  all_done_q, all_done_d;
  logic                  timeout_q, timeout_d;
  logic [FW-1:0]         fail_q, fail_d;
  logic [3:0]            retry_q, retry_d;
  logic                  fault_q, fault_d;
  logic [HB_BIT:0]       hb_cnt_q, hb_cnt_d;
  logic                  hb_q, hb_d;
  logic                  ext_active;

  // Synchroniser resets to the "pin asserted" value so the system starts held.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      ext_meta_q <= 1'b0;
      ext_sync_q <= 1'b0;
    end else begin
      ext_meta_q <= ext_rst_n_i;
      ext_sync_q <= ext_meta_q;
    end
  end

  assign ext_active = ~ext_sync_q;
  assign cnt_inc    = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    rst_d     = rst_q;
    timeout_d = timeout_q;
    fail_d    = fail_q;
    retry_d   = retry_q;
    case (state_q)
      ST_ASSERT: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d = ST_RELEASE;
          stage_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RELEASE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (stage_done_i[stage_q]) begin
          if (stage_q == SW'(NUM_STAGES - 1)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_RELEASE;
            stage_d = stage_q + 1'b1;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          fail_d    = FW'(stage_q);
          if (retry_q < 4'(MAX_RETRIES)) begin
            retry_d = retry_q + 4'd1;
            state_d = ST_ASSERT;
          end else begin
            state_d = ST_FAULT;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RUN: begin
        if (!(&stage_done_i)) state_d = ST_ASSERT;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: state_d = ST_ASSERT;
    endcase

    if (ext_active) begin
      state_d = ST_ASSERT;
      retry_d = '0;
    end

    // Reset outputs follow the next state so they change in the cycle the state does.
    if (state_d == ST_ASSERT) begin
      rst_d = '1;
      if (state_q != ST_ASSERT || ext_active) cnt_d = '0;
    end
    if (state_d == ST_RELEASE) rst_d[stage_d] = 1'b0;
    if (state_d == ST_FAULT && state_q != ST_FAULT) rst_d[stage_q] = 1'b1;

    all_done_d = (state_q == ST_RUN) && (state_d == ST_RUN);
    fault_d    = (state_d == ST_FAULT);
    hb_cnt_d   = hb_cnt_q + 1'b1;
    hb_d       = (state_q == ST_FAULT) ? hb_cnt_q[HB_BIT-2] : hb_cnt_q[HB_BIT];
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q    <= ST_ASSERT;
      stage_q    <= '0;
      cnt_q      <= '0;
      rst_q      <= '1;
      all_done_q <= 1'b0;
      timeout_q  <= 1'b0;
      fail_q     <= '0;
      retry_q    <= '0;
      fault_q    <= 1'b0;
      hb_cnt_q   <= '0;
      hb_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      cnt_q      <= cnt_d;
      rst_q      <= rst_d;
      all_done_q <= all_done_d;
      timeout_q  <= timeout_d;
      fail_q     <= fail_d;
      retry_q    <= retry_d;
      fault_q    <= fault_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_q       <= hb_d;
    end
  end

  assign stage_rst_o  = rst_q;
  assign all_done_o   = all_done_q;
  assign timeout_o    = timeout_q;
  assign fail_stage_o = fail_q;
  assign retry_cnt_o  = retry_q;
  assign fault_o      = fault_q;
  assign heartbeat_o  = hb_q;

endmodule
